mc_core: RTL and testbench
==========================

Name: mc_core

Overview:
- Parametrised multi-cycle MIPS-subset core. It is the successor to the single-cycle datapath: the datapath is shared across 3–5 states per instruction and sequenced by an internal FSM.
- Contains its own program counter, instruction memory (loadable while stopped), data memory, 32-entry register file and ALU.
- Sits at top level under a testbench or loader. Exposes run/halt control, retire strobes and a register debug port.

Parameters:
- DATA_W, 32, datapath and register width; must be ≥ 32 and a multiple of 8.
- IMEM_DEPTH, 32, instruction words; power of 2.
- DMEM_DEPTH, 32, data words; power of 2.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start/continue execution.
- imem_we  in  1  program-load write enable; honoured only in IDLE or HALT.
- imem_waddr  in  clog2(IMEM_DEPTH)  program-load word index.
- imem_wdata  in  32  program-load instruction word.
- dbg_raddr  in  5  register-file debug read index.
- dbg_rdata  out  DATA_W  combinational read of reg[dbg_raddr]; reg 0 reads 0.
- pc  out  clog2(IMEM_DEPTH)+2  byte-address PC.
- state  out  3  FSM state encoding.
- retire  out  1  one-cycle pulse per completed instruction.
- instr_count  out  CNT_W  retired instruction count.
- halted  out  1  high in HALT.
- error  out  1  sticky: illegal opcode or misaligned data access.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; pc=0; IR, A, B and ALUOut cleared; all registers cleared.
  - retire=0, instr_count=0, halted=0, error=0.
  - Instruction and data memory contents are retained.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: imem writes accepted. run=1 → FETCH.
- FETCH: IR←imem[pc[AW+1:2]]; pc←pc+4, wrapping modulo 4*IMEM_DEPTH. → DECODE.
- DECODE:
  - A←reg[rs], B←reg[rt]; reg 0 always reads 0.
  - Branch target precomputed: pc+(sext(imm16)<<2).
  - opcode 0x3F (halt) → HALT.
  - Illegal opcode, or R-type funct not in {0x20,0x22,0x24,0x25,0x2A} → error=1, HALT.
  - Otherwise → EXEC.
- EXEC:
  - R-type: ALUOut←A op B. funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). → WB.
  - addi 0x08 / lw 0x23 / sw 0x2B: ALUOut←A+sext(imm16). addi → WB; lw/sw → MEM.
  - beq 0x04: if A==B, pc←target. Instruction completes.
  - j 0x02: pc←{pc[top:28 or truncated], imm26<<2} truncated to pc width. Completes.
- MEM:
  - ALUOut[1:0]≠0 → error=1, HALT; no write, no retire.
  - Word index = ALUOut[DW+1:2], truncated (wraps).
  - lw: MDR←dmem[idx] → WB.
  - sw: dmem[idx]←B; completes.
- WB:
  - Destination is rd for R-type, rt for lw/addi.
  - Data is ALUOut for R-type/addi, MDR for lw.
  - Writes to reg 0 are ignored. Completes.
- Completion: on the completing cycle the next state is FETCH if run=1, else IDLE. retire is registered and high the following cycle; instr_count increments, wrapping at 2^CNT_W.
- Latencies (cycles FETCH→completion): beq 3, j 3, R-type 4, addi 4, sw 4, lw 5.
- HALT:
  - halted=1; imem writes accepted.
  - Stays while run=1. run=0 → IDLE with pc←0 and error cleared; registers and instr_count kept.
  - The halt instruction does not retire.
- run=0 mid-instruction: the current instruction finishes, then the FSM enters IDLE with pc preserved. run=1 resumes at pc.
- imem_we outside IDLE/HALT: ignored.
- A register write and a dbg_raddr read of the same register in the same cycle: dbg_rdata shows the old value.

Test Plan:
- Reset mid-EXEC:
  - Run a program, then pulse reset=0 for 3 ns during EXEC.
  - Required: state=0, pc=0, instr_count=0 immediately (asynchronously). A dmem word written earlier is still readable by a subsequent lw.
- addi/sw/lw sequence:
  - Load addi $1,$0,0x55; sw $1,12($0); lw $2,12($0); halt. Pulse run.
  - Required: dbg reg2=0x55; retire pulses at cycles 4, 8, 13 after FETCH entry; instr_count=3; halted=1.
- R-type:
  - $1=7, $2=-3.
  - Required: sub $3,$1,$2 gives 10; slt $4,$2,$1 gives 1; add $0,$1,$1 leaves reg0=0.
- beq:
  - beq $1,$1,+2 at pc 8: pc=20 after 3 cycles.
  - beq with unequal operands: pc=12.
- Errors:
  - Illegal opcode 0x3E: error=1, HALT, instr_count unchanged.
  - lw at address 0x0D: error=1, no register written.
  - Drop run: state=IDLE, pc=0, error=0.
- Load and run control:
  - imem_we asserted during FETCH: memory unchanged.
  - run dropped during a lw's MEM state: lw still writes back, state goes IDLE, pc=next; run=1 resumes there.

Source files
------------

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle MIPS-subset core: FSM-sequenced shared datapath
// Owns its PC, instruction/data memories, 32-entry register file and ALU.
module mc_core #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic [$clog2(IMEM_DEPTH)+1:0] pc,
  output logic [2:0]                    state,
  output logic                          retire,
  output logic [CNT_W-1:0]              instr_count,
  output logic                          halted,
  output logic                          error
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam int PW = AW + 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              retire_q, retire_d, error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [32];

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, rs_val, rt_val, alu_r;
  logic              funct_ok;
  logic [DW-1:0]     dmem_idx;
  logic              dmem_we, rf_we, done;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [PW-1:0]     jmp_pc;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = DATA_W'($signed(ir_q[15:0]));
  assign rs_val   = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs_q[rt];
  assign dmem_idx = alu_q[DW+1:2];
  assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  // Jump keeps the PC bits above the 28-bit region only when the PC is that wide.
  if (PW > 28) begin : g_jmp_hi
    assign jmp_pc = {pc_q[PW-1:28], ir_q[25:0], 2'b00};
  end else begin : g_jmp_lo
    assign jmp_pc = PW'({ir_q[25:0], 2'b00});
  end

  always_comb begin
    alu_r = '0;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    tgt_d    = tgt_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    error_d  = error_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    dmem_we  = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = imem[pc_q[PW-1:2]];
        pc_d    = pc_q + PW'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        tgt_d = pc_q + PW'($signed({ir_q[15:0], 2'b00}));
        case (opcode)
          OP_HALT:  state_d = S_HALT;
          OP_RTYPE: begin
            state_d = funct_ok ? S_EXEC : S_HALT;
            error_d = error_q | ~funct_ok;
          end
          OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
          default: begin
            error_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_d   = alu_r;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_sext;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = tgt_q;
            done = 1'b1;
          end
          OP_J: begin
            pc_d = jmp_pc;
            done = 1'b1;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (alu_q[1:0] != 2'b00) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else if (opcode == OP_LW) begin
          mdr_d   = dmem[dmem_idx];
          state_d = S_WB;
        end else begin
          dmem_we = 1'b1;
          done    = 1'b1;
        end
      end
      S_WB: begin
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        rf_we    = (rf_waddr != 5'd0);
        done     = 1'b1;
      end
      S_HALT: begin
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Finishing an instruction always lands in FETCH or IDLE depending on run.
    if (done) begin
      retire_d = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
      state_d  = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      tgt_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (imem_we && (state_q == S_IDLE || state_q == S_HALT)) imem[imem_waddr] <= imem_wdata;
    if (dmem_we) dmem[dmem_idx] <= b_q;
  end

  assign dbg_rdata   = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];
  assign pc          = pc_q;
  assign state       = state_q;
  assign retire      = retire_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign error       = error_q;
endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - scoreboard bench for mc_core
`timescale 1ns/1ps
module tb_mc_core;
  localparam int K_STATE = 0, K_PC = 1, K_CNT = 2, K_HALT = 3, K_ERR = 4, K_REG = 5, K_RET = 6, K_PEND = 7;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_MEM = 3'd4, S_HALT = 3'd6;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;
  localparam logic [31:0] W_ILL  = 32'hF800_0000;

  typedef struct { string name; int kind; logic [31:0] exp; } chk_t;
  typedef struct { int cnt; int pcv; int cyc; } ret_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [6:0]  pc;
  logic [2:0]  state;
  logic        retire;
  logic [15:0] instr_count;
  logic        halted;
  logic        error;

  chk_t chk_q[$];
  ret_t ret_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   f;

  mc_core dut (
    .clk(clk), .reset(reset), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
    .state(state), .retire(retire), .instr_count(instr_count), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    ret_t r;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_STATE: act = {29'd0, state};
        K_PC:    act = {25'd0, pc};
        K_CNT:   act = {16'd0, instr_count};
        K_HALT:  act = {31'd0, halted};
        K_ERR:   act = {31'd0, error};
        K_REG:   act = dbg_rdata;
        K_RET:   act = {31'd0, retire};
        default: act = 32'(ret_q.size());
      endcase
      compare(c.name, act, c.exp);
    end
    if (retire === 1'b1) begin
      if (ret_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_retire: got retire with count %0d, required no retire", instr_count);
      end else begin
        r = ret_q.pop_front();
        compare("retire_count", {16'd0, instr_count}, r.cnt);
        compare("retire_pc", {25'd0, pc}, r.pcv);
        if (r.cyc >= 0) compare("retire_cycle", cyc, r.cyc);
      end
    end
  end

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic push_chk(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    chk_q.push_back(c);
  endtask
  task automatic exp_ret(input int cnt, input int pcv, input int cy);
    ret_t r;
    r.cnt = cnt; r.pcv = pcv; r.cyc = cy;
    ret_q.push_back(r);
  endtask
  task automatic load(input logic [4:0] a, input logic [31:0] w);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = w;
    sync();
    imem_we = 1'b0;
  endtask
  task automatic chk_reg(input logic [4:0] r, input logic [31:0] exp, input string name);
    dbg_raddr = r;
    push_chk(name, K_REG, exp);
    sync();
  endtask
  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    for (int i = 0; i < budget && state != st; i++) sync();
    push_chk(name, K_STATE, {29'd0, st});
  endtask
  task automatic stop_run(input string name);
    run = 1'b0;
    sync();
    push_chk({name, "_state"}, K_STATE, 32'd0);
    push_chk({name, "_pc"}, K_PC, 32'd0);
    push_chk({name, "_error"}, K_ERR, 32'd0);
    push_chk({name, "_halted"}, K_HALT, 32'd0);
    sync();
  endtask

  initial begin
    // Reset values
    push_chk("rst_state", K_STATE, 0);
    push_chk("rst_pc", K_PC, 0);
    push_chk("rst_count", K_CNT, 0);
    push_chk("rst_halted", K_HALT, 0);
    push_chk("rst_error", K_ERR, 0);
    push_chk("rst_retire", K_RET, 0);
    sync(); sync();
    reset = 1'b1;
    chk_reg(5'd5, 32'd0, "rst_reg5");

    // addi / sw / lw with exact retire timing
    load(5'd0, i_type(6'h08, 5'd0, 5'd1, 16'h0055));
    load(5'd1, i_type(6'h2B, 5'd0, 5'd1, 16'd12));
    load(5'd2, i_type(6'h23, 5'd0, 5'd2, 16'd12));
    load(5'd3, W_HALT);
    f = cyc + 1;
    exp_ret(1, 4, f + 4); exp_ret(2, 8, f + 8); exp_ret(3, 12, f + 13);
    run = 1'b1;
    wait_state(S_HALT, 60, "seq_halt");
    push_chk("seq_halted", K_HALT, 1);
    push_chk("seq_count", K_CNT, 3);
    push_chk("seq_error", K_ERR, 0);
    chk_reg(5'd2, 32'h55, "seq_reg2");
    stop_run("seq_stop");

    // R-type with $1=7, $2=-3
    load(5'd0, i_type(6'h08, 5'd0, 5'd1, 16'd7));
    load(5'd1, i_type(6'h08, 5'd0, 5'd2, 16'hFFFD));
    load(5'd2, r_type(5'd1, 5'd2, 5'd3, 6'h22));
    load(5'd3, r_type(5'd2, 5'd1, 5'd4, 6'h2A));
    load(5'd4, r_type(5'd1, 5'd1, 5'd0, 6'h20));
    load(5'd5, r_type(5'd1, 5'd2, 5'd5, 6'h24));
    load(5'd6, r_type(5'd1, 5'd2, 5'd6, 6'h25));
    load(5'd7, W_HALT);
    for (int i = 0; i < 7; i++) exp_ret(4 + i, 4 * (i + 1), -1);
    run = 1'b1;
    wait_state(S_HALT, 100, "rt_halt");
    push_chk("rt_count", K_CNT, 10);
    chk_reg(5'd3, 32'd10, "rt_sub");
    chk_reg(5'd4, 32'd1, "rt_slt");
    chk_reg(5'd0, 32'd0, "rt_reg0");
    chk_reg(5'd5, 32'd5, "rt_and");
    chk_reg(5'd6, 32'hFFFF_FFFF, "rt_or");
    stop_run("rt_stop");

    // beq taken/not taken and j
    load(5'd0, i_type(6'h08, 5'd0, 5'd7, 16'd1));
    load(5'd1, i_type(6'h08, 5'd0, 5'd8, 16'd2));
    load(5'd2, i_type(6'h04, 5'd1, 5'd1, 16'd2));
    load(5'd3, i_type(6'h08, 5'd0, 5'd9, 16'h33));
    load(5'd4, i_type(6'h08, 5'd0, 5'd9, 16'h44));
    load(5'd5, i_type(6'h04, 5'd1, 5'd2, 16'd1));
    load(5'd6, {6'h02, 26'd8});
    load(5'd7, i_type(6'h08, 5'd0, 5'd9, 16'h77));
    load(5'd8, W_HALT);
    f = cyc + 1;
    exp_ret(11, 4, f + 4); exp_ret(12, 8, f + 8); exp_ret(13, 20, f + 11);
    exp_ret(14, 24, f + 14); exp_ret(15, 32, f + 17);
    run = 1'b1;
    wait_state(S_HALT, 100, "br_halt");
    push_chk("br_count", K_CNT, 15);
    chk_reg(5'd9, 32'd0, "br_skipped");
    stop_run("br_stop");

    // Illegal opcode 0x3E
    load(5'd0, W_ILL);
    run = 1'b1;
    wait_state(S_HALT, 20, "ill_halt");
    push_chk("ill_error", K_ERR, 1);
    push_chk("ill_count", K_CNT, 15);
    sync();
    stop_run("ill_stop");

    // Misaligned lw at 0x0D
    load(5'd0, i_type(6'h23, 5'd0, 5'd10, 16'h000D));
    run = 1'b1;
    wait_state(S_HALT, 20, "mis_halt");
    push_chk("mis_error", K_ERR, 1);
    push_chk("mis_count", K_CNT, 15);
    chk_reg(5'd10, 32'd0, "mis_reg10");
    stop_run("mis_stop");

    // imem write attempted during FETCH is ignored
    load(5'd0, i_type(6'h08, 5'd0, 5'd11, 16'h11));
    load(5'd1, W_HALT);
    exp_ret(16, 4, -1);
    run = 1'b1;
    sync();
    push_chk("we_in_fetch", K_STATE, {29'd0, S_FETCH});
    imem_we = 1'b1; imem_waddr = 5'd1; imem_wdata = i_type(6'h08, 5'd0, 5'd12, 16'h99);
    sync();
    imem_we = 1'b0;
    wait_state(S_HALT, 30, "we_halt");
    push_chk("we_count", K_CNT, 16);
    chk_reg(5'd12, 32'd0, "we_reg12");
    chk_reg(5'd11, 32'h11, "we_reg11");
    stop_run("we_stop");

    // run dropped during lw MEM, then resumed
    load(5'd0, i_type(6'h23, 5'd0, 5'd13, 16'd12));
    load(5'd1, i_type(6'h08, 5'd0, 5'd14, 16'h22));
    load(5'd2, W_HALT);
    exp_ret(17, 4, -1);
    run = 1'b1;
    wait_state(S_MEM, 10, "pause_mem");
    run = 1'b0;
    sync();
    wait_state(S_IDLE, 10, "pause_idle");
    push_chk("pause_pc", K_PC, 4);
    chk_reg(5'd13, 32'h55, "pause_reg13");
    exp_ret(18, 8, -1);
    run = 1'b1;
    wait_state(S_HALT, 30, "resume_halt");
    chk_reg(5'd14, 32'h22, "resume_reg14");
    stop_run("resume_stop");

    // Asynchronous reset during EXEC
    load(5'd0, i_type(6'h08, 5'd0, 5'd15, 16'd1));
    load(5'd1, W_HALT);
    run = 1'b1;
    wait_state(S_DECODE, 10, "ar_decode");
    sync();
    #2;
    reset = 1'b0;
    run = 1'b0;
    push_chk("ar_state", K_STATE, 0);
    push_chk("ar_pc", K_PC, 0);
    push_chk("ar_count", K_CNT, 0);
    #3;
    reset = 1'b1;
    sync();
    chk_reg(5'd15, 32'd0, "ar_reg15");
    chk_reg(5'd2, 32'd0, "ar_reg2");
    load(5'd0, i_type(6'h23, 5'd0, 5'd2, 16'd12));
    load(5'd1, W_HALT);
    exp_ret(1, 4, -1);
    run = 1'b1;
    wait_state(S_HALT, 30, "ar_halt");
    chk_reg(5'd2, 32'h55, "ar_dmem_kept");
    stop_run("ar_stop");

    push_chk("retire_queue_drained", K_PEND, 0);
    sync(); sync();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
